// File: rtl/morse_pkg.sv
// Shared timing thresholds, state encoding and element classifier
// for the Morse key front end.
package morse_pkg;

   localparam int DUR_W = 4;
   localparam int LEN_W = 3;

   localparam logic [DUR_W-1:0] DIT_MAX  = 4'd1;
   localparam logic [DUR_W-1:0] DASH_MAX = 4'd6;
   localparam logic [DUR_W-1:0] CHAR_GAP = 4'd3;
   localparam logic [DUR_W-1:0] WORD_GAP = 4'd7;
   localparam logic [DUR_W-1:0] DUR_SAT  = 4'd15;

   localparam logic [DUR_W-1:0] CHAR_LAST = CHAR_GAP - 4'd1;
   localparam logic [DUR_W-1:0] WORD_LAST = WORD_GAP - 4'd1;

   localparam logic [LEN_W-1:0] MAX_ELEMS = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MARK = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MARK = ST_MARK,
      GAP  = ST_GAP
   } state_e;

   typedef enum logic [1:0] {
      EL_DIT,
      EL_DASH,
      EL_BAD
   } elem_e;

   function automatic elem_e classify(
      input logic [DUR_W-1:0] dur
   );
      elem_e e;
      e = EL_BAD;
      if (dur <= DASH_MAX) e = EL_DASH;
      if (dur <= DIT_MAX)  e = EL_DIT;
      return e;
   endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Dit-unit prescaler: free-running modulo counter that can be
// realigned to a key edge, emitting one tick per unit.
module morse_unit_tick #(
   parameter int CLK_PER_UNIT = 1000,
   parameter int PRE_W        = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o
);

   localparam logic [PRE_W-1:0] LAST =
      PRE_W'(CLK_PER_UNIT - 1);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + PRE_W'(1);
      if (restart_i || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/morse_key_timer.sv
// Morse key front end: synchronise, time marks/gaps in dit units,
// classify elements and hand them to texter_control.
module morse_key_timer
   import morse_pkg::*;
#(
   parameter int CLK_PER_UNIT = 1000,
   parameter int PRE_W        = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_in,
   input  logic             nxt_bit,
   input  logic             out_space,
   output logic             dash_dit,
   output logic             sym_is_dash,
   output logic             dc_error,
   output logic             space,
   output logic             char_end,
   output logic [4:0]       sym_code,
   output logic [LEN_W-1:0] sym_len
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   key_s;
   logic                   key_d1_q;
   logic                   armed_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   ev;
   logic                   tick;
   logic [DUR_W-1:0]       dur_q;

   state_e                 state_q;
   logic                   dash_dit_q;
   logic                   sym_is_dash_q;
   logic                   dc_error_q;
   logic                   space_q;
   logic                   char_end_q;
   logic [4:0]             sym_code_q;
   logic [LEN_W-1:0]       sym_len_q;

   elem_e                  elem;
   logic                   ack;
   logic                   bad;

   assign key_s = sync_q[SYNC_STAGES-1];
   assign ev    = rise_q | fall_q;

   // Edges are only honoured once the key has been seen released
   // after reset, so a key held through reset is ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q   <= '0;
         fill_q   <= '0;
         key_d1_q <= 1'b0;
         armed_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], key_in};
         fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         key_d1_q <= key_s;
         if (fill_q[SYNC_STAGES-1] && !key_s) armed_q <= 1'b1;
         rise_q   <= armed_q & key_s & ~key_d1_q;
         fall_q   <= armed_q & ~key_s & key_d1_q;
      end
   end

   morse_unit_tick #(
      .CLK_PER_UNIT (CLK_PER_UNIT),
      .PRE_W        (PRE_W)
   ) u_tick (
      .clk       (clk),
      .reset     (reset),
      .restart_i (ev),
      .tick_o    (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         dur_q <= '0;
      end else if (ev) begin
         dur_q <= '0;
      end else if (tick && dur_q != DUR_SAT) begin
         dur_q <= dur_q + 4'd1;
      end
   end

   assign elem = classify(dur_q);
   assign ack  = nxt_bit & dash_dit_q;
   assign bad  = (elem == EL_BAD)
               | (sym_len_q == MAX_ELEMS)
               | (dash_dit_q & ~nxt_bit);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         dash_dit_q    <= 1'b0;
         sym_is_dash_q <= 1'b0;
         dc_error_q    <= 1'b0;
         space_q       <= 1'b0;
         char_end_q    <= 1'b0;
         sym_code_q    <= '0;
         sym_len_q     <= '0;
      end else begin
         char_end_q <= 1'b0;
         if (out_space) space_q <= 1'b0;
         if (ack) begin
            dash_dit_q    <= 1'b0;
            sym_is_dash_q <= 1'b0;
            dc_error_q    <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (rise_q) state_q <= MARK;
            end
            MARK: begin
               // A fall overrides a same-cycle ack with the new element.
               if (fall_q) begin
                  dash_dit_q    <= 1'b1;
                  sym_is_dash_q <= (elem != EL_DIT);
                  dc_error_q    <= bad;
                  if (!bad) begin
                     sym_code_q[sym_len_q] <= (elem == EL_DASH);
                     sym_len_q <= sym_len_q + 3'd1;
                  end
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (rise_q) begin
                  state_q <= MARK;
               end else if (tick) begin
                  if (dur_q == CHAR_LAST && sym_len_q != '0) begin
                     char_end_q <= 1'b1;
                     sym_code_q <= '0;
                     sym_len_q  <= '0;
                  end
                  if (dur_q == WORD_LAST) begin
                     space_q <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dash_dit    = dash_dit_q;
   assign sym_is_dash = sym_is_dash_q;
   assign dc_error    = dc_error_q;
   assign space       = space_q;
   assign char_end    = char_end_q;
   assign sym_code    = sym_code_q;
   assign sym_len     = sym_len_q;

endmodule
